sync_fifo: RTL and testbench

Single-clock, parametrised FIFO for buffering datapath words between producer and consumer stages in the same clock domain (e.g. operand/result queues around the multiply and divide units). Generalises the existing FIFO in depth (non-power-of-two supported), read mode (normal or show-ahead), and status (occupancy count, programmable almost-full/almost-empty, sticky overflow/underflow, synchronous clear).

---
 rtl/fifo_pkg.sv | 10 +
 rtl/sync_fifo_ram.sv | 24 ++
 rtl/sync_fifo.sv | 127 ++++++++++++
 tb/tb_sync_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Helpers shared by the FIFO family: pointer increment with explicit wrap so
// that depths which are not a power of two work without modulo arithmetic.
package fifo_pkg;

  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                          input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo: registered write, asynchronous read
// so the head word can be presented combinationally in show-ahead mode.
module sync_fifo_ram #(
  parameter int DATA_LEN   = 16,
  parameter int ADDR_LEN   = 4,
  parameter int FIFO_DEPTH = 1 << ADDR_LEN
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_LEN-1:0] waddr,
  input  logic [DATA_LEN-1:0] wdata,
  input  logic [ADDR_LEN-1:0] raddr,
  output logic [DATA_LEN-1:0] rdata
);

  logic [DATA_LEN-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, normal or show-ahead read, registered
// occupancy/status flags, sticky overflow/underflow and synchronous clear.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_LEN        = 16,
  parameter int ADDR_LEN        = 4,
  parameter int FIFO_DEPTH      = 1 << ADDR_LEN,
  parameter int SHOWAHEAD       = 0,
  parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sclr,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic                wrt_en,
  output logic                wrt_full,
  output logic                almost_full,
  output logic [DATA_LEN-1:0] data_out,
  input  logic                rd_en,
  output logic                rd_empty,
  output logic                almost_empty,
  output logic [ADDR_LEN:0]   usedw,
  output logic                overflow,
  output logic                underflow
);

  localparam logic AFULL_RST = (ALMOST_FULL_TH == 0);

  logic [ADDR_LEN-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_LEN:0]   usedw_q, usedw_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic                afull_q, afull_d, aempty_q, aempty_d;
  logic                ovf_q, ovf_d, udf_q, udf_d;
  logic [DATA_LEN-1:0] dout_q, dout_d;
  logic [DATA_LEN-1:0] ram_rdata;
  logic                wr_acc, rd_acc;

  assign wr_acc = wrt_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  sync_fifo_ram #(
    .DATA_LEN  (DATA_LEN),
    .ADDR_LEN  (ADDR_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc && !sclr),
    .waddr(wr_ptr_q),
    .wdata(data_in),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    dout_d   = dout_q;
    if (sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      dout_d   = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ADDR_LEN'(ptr_inc(32'(wr_ptr_q), 32'(FIFO_DEPTH)));
      if (rd_acc) begin
        rd_ptr_d = ADDR_LEN'(ptr_inc(32'(rd_ptr_q), 32'(FIFO_DEPTH)));
        dout_d   = ram_rdata;
      end
      case ({wr_acc, rd_acc})
        2'b10:   usedw_d = usedw_q + 1'b1;
        2'b01:   usedw_d = usedw_q - 1'b1;
        default: usedw_d = usedw_q;
      endcase
      ovf_d = ovf_q | (wrt_en & full_q);
      udf_d = udf_q | (rd_en & empty_q);
    end
    // Flags come from next occupancy so they change on the same edge as usedw.
    full_d   = (32'(usedw_d) == 32'(FIFO_DEPTH));
    empty_d  = (usedw_d == '0);
    afull_d  = (32'(usedw_d) >= 32'(ALMOST_FULL_TH));
    aempty_d = (32'(usedw_d) <= 32'(ALMOST_EMPTY_TH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= AFULL_RST;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dout_q   <= dout_d;
    end
  end

  // Show-ahead exposes the RAM head directly, forced to zero while empty.
  assign data_out     = (SHOWAHEAD != 0) ? (empty_q ? '0 : ram_rdata) : dout_q;
  assign wrt_full     = full_q;
  assign rd_empty     = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign usedw        = usedw_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: depth-16 normal, depth-12 normal (wrap) and
// depth-16 show-ahead instances sharing one clock and reset.
module tb_sync_fifo;

  logic clk, reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        n_sclr, n_wr, n_rd, n_full, n_af, n_empty, n_ae, n_ovf, n_udf;
  logic [15:0] n_din, n_dout;
  logic [4:0]  n_usedw;
  logic        w_sclr, w_wr, w_rd, w_full, w_af, w_empty, w_ae, w_ovf, w_udf;
  logic [15:0] w_din, w_dout;
  logic [4:0]  w_usedw;
  logic        s_sclr, s_wr, s_rd, s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
  logic [15:0] s_din, s_dout;
  logic [4:0]  s_usedw;

  sync_fifo #(.DATA_LEN(16), .ADDR_LEN(4), .FIFO_DEPTH(16), .SHOWAHEAD(0)) u_n (
    .clk(clk), .reset_n(reset_n), .sclr(n_sclr), .data_in(n_din), .wrt_en(n_wr),
    .wrt_full(n_full), .almost_full(n_af), .data_out(n_dout), .rd_en(n_rd),
    .rd_empty(n_empty), .almost_empty(n_ae), .usedw(n_usedw),
    .overflow(n_ovf), .underflow(n_udf));

  sync_fifo #(.DATA_LEN(16), .ADDR_LEN(4), .FIFO_DEPTH(12), .SHOWAHEAD(0)) u_w (
    .clk(clk), .reset_n(reset_n), .sclr(w_sclr), .data_in(w_din), .wrt_en(w_wr),
    .wrt_full(w_full), .almost_full(w_af), .data_out(w_dout), .rd_en(w_rd),
    .rd_empty(w_empty), .almost_empty(w_ae), .usedw(w_usedw),
    .overflow(w_ovf), .underflow(w_udf));

  sync_fifo #(.DATA_LEN(16), .ADDR_LEN(4), .FIFO_DEPTH(16), .SHOWAHEAD(1)) u_s (
    .clk(clk), .reset_n(reset_n), .sclr(s_sclr), .data_in(s_din), .wrt_en(s_wr),
    .wrt_full(s_full), .almost_full(s_af), .data_out(s_dout), .rd_en(s_rd),
    .rd_empty(s_empty), .almost_empty(s_ae), .usedw(s_usedw),
    .overflow(s_ovf), .underflow(s_udf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    {n_sclr, n_wr, n_rd, w_sclr, w_wr, w_rd, s_sclr, s_wr, s_rd} = '0;
    n_din = '0; w_din = '0; s_din = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    n_checks++; if (n_usedw !== 5'd0) begin n_fail++; $display("FAIL reset_usedw: got %0d want 0", n_usedw); end
    n_checks++; if (n_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", n_empty); end
    n_checks++; if (n_ae !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b want 1", n_ae); end
    n_checks++; if (n_full !== 1'b0 || n_af !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b%b want 00", n_full, n_af); end
    n_checks++; if (n_ovf !== 1'b0 || n_udf !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b%b want 00", n_ovf, n_udf); end
    n_checks++; if (n_dout !== 16'h0 || s_dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout: got %h/%h want 0", n_dout, s_dout); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      n_din = 16'(i); n_wr = 1'b1;
      tick();
      n_checks++; if (n_usedw !== 5'(i)) begin n_fail++; $display("FAIL fill_usedw[%0d]: got %0d want %0d", i, n_usedw, i); end
      n_checks++; if (n_af !== (i >= 14)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b want %b", i, n_af, (i >= 14)); end
      n_checks++; if (n_full !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, n_full, (i == 16)); end
      n_checks++; if (n_ae !== (i <= 2)) begin n_fail++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, n_ae, (i <= 2)); end
      n_checks++; if (n_empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d]: got %b want 0", i, n_empty); end
    end
    n_din = 16'h0011;
    tick();
    n_wr = 1'b0;
    n_checks++; if (n_ovf !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %b want 1", n_ovf); end
    n_checks++; if (n_usedw !== 5'd16 || n_full !== 1'b1) begin n_fail++; $display("FAIL fill_after_ovf: usedw %0d full %b want 16 1", n_usedw, n_full); end
  endtask

  task automatic test_drain();
    n_rd = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_checks++; if (n_dout !== 16'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, n_dout, 16'(i)); end
      n_checks++; if (n_usedw !== 5'(16 - i)) begin n_fail++; $display("FAIL drain_usedw[%0d]: got %0d want %0d", i, n_usedw, 16 - i); end
    end
    n_checks++; if (n_empty !== 1'b1 || n_udf !== 1'b0) begin n_fail++; $display("FAIL drain_empty: empty %b udf %b want 1 0", n_empty, n_udf); end
    tick();
    n_rd = 1'b0;
    n_checks++; if (n_udf !== 1'b1) begin n_fail++; $display("FAIL drain_underflow: got %b want 1", n_udf); end
    n_checks++; if (n_dout !== 16'h0010) begin n_fail++; $display("FAIL drain_hold: got %h want 0010", n_dout); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      w_din = 16'h0100 + 16'(i); w_wr = 1'b1;
      tick();
    end
    n_checks++; if (w_usedw !== 5'd5) begin n_fail++; $display("FAIL wrap_prefill: got %0d want 5", w_usedw); end
    w_rd = 1'b1;
    for (int k = 0; k < 30; k++) begin
      w_din = 16'h0105 + 16'(k);
      tick();
      n_checks++; if (w_dout !== 16'h0100 + 16'(k)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", k, w_dout, 16'h0100 + 16'(k)); end
      n_checks++; if (w_usedw !== 5'd5) begin n_fail++; $display("FAIL wrap_usedw[%0d]: got %0d want 5", k, w_usedw); end
    end
    w_wr = 1'b0; w_rd = 1'b0;
    n_checks++; if (w_ovf !== 1'b0 || w_udf !== 1'b0 || w_full !== 1'b0) begin n_fail++; $display("FAIL wrap_flags: ovf %b udf %b full %b want 000", w_ovf, w_udf, w_full); end
  endtask

  task automatic test_showahead();
    n_checks++; if (s_dout !== 16'h0 || s_empty !== 1'b1) begin n_fail++; $display("FAIL sa_idle: dout %h empty %b want 0000 1", s_dout, s_empty); end
    s_din = 16'hA5A5; s_wr = 1'b1;
    tick();
    s_wr = 1'b0;
    n_checks++; if (s_empty !== 1'b0) begin n_fail++; $display("FAIL sa_empty: got %b want 0", s_empty); end
    n_checks++; if (s_dout !== 16'hA5A5) begin n_fail++; $display("FAIL sa_head: got %h want a5a5", s_dout); end
    s_rd = 1'b1;
    tick();
    s_rd = 1'b0;
    n_checks++; if (s_dout !== 16'h0 || s_empty !== 1'b1) begin n_fail++; $display("FAIL sa_pop: dout %h empty %b want 0000 1", s_dout, s_empty); end
  endtask

  task automatic test_full_simul();
    n_sclr = 1'b1;
    tick();
    n_sclr = 1'b0;
    n_checks++; if (n_ovf !== 1'b0 || n_udf !== 1'b0 || n_dout !== 16'h0) begin n_fail++; $display("FAIL sclr_first: ovf %b udf %b dout %h want 0 0 0000", n_ovf, n_udf, n_dout); end
    n_wr = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      n_din = 16'h0200 + 16'(i);
      tick();
    end
    n_checks++; if (n_usedw !== 5'd16 || n_full !== 1'b1) begin n_fail++; $display("FAIL simul_full: usedw %0d full %b want 16 1", n_usedw, n_full); end
    n_din = 16'h0BAD; n_rd = 1'b1;
    tick();
    n_rd = 1'b0;
    n_checks++; if (n_usedw !== 5'd15 || n_full !== 1'b0) begin n_fail++; $display("FAIL simul_usedw: usedw %0d full %b want 15 0", n_usedw, n_full); end
    n_checks++; if (n_ovf !== 1'b1) begin n_fail++; $display("FAIL simul_overflow: got %b want 1", n_ovf); end
    n_checks++; if (n_dout !== 16'h0201) begin n_fail++; $display("FAIL simul_data: got %h want 0201", n_dout); end
    n_sclr = 1'b1;
    tick();
    n_sclr = 1'b0; n_wr = 1'b0;
    n_checks++; if (n_usedw !== 5'd0 || n_empty !== 1'b1) begin n_fail++; $display("FAIL sclr_usedw: usedw %0d empty %b want 0 1", n_usedw, n_empty); end
    n_checks++; if (n_ovf !== 1'b0 || n_dout !== 16'h0 || n_af !== 1'b0) begin n_fail++; $display("FAIL sclr_state: ovf %b dout %h af %b want 0 0000 0", n_ovf, n_dout, n_af); end
  endtask

  task automatic test_async_reset();
    n_wr = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      n_din = 16'h0300 + 16'(i);
      tick();
    end
    n_rd = 1'b1; n_wr = 1'b0;
    tick();
    n_rd = 1'b0;
    n_checks++; if (n_usedw !== 5'd6 || n_dout !== 16'h0301) begin n_fail++; $display("FAIL areset_pre: usedw %0d dout %h want 6 0301", n_usedw, n_dout); end
    n_wr = 1'b1; n_din = 16'h0308;
    tick();
    n_wr = 1'b0;
    n_checks++; if (n_usedw !== 5'd7) begin n_fail++; $display("FAIL areset_mid: got %0d want 7", n_usedw); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (n_usedw !== 5'd0 || n_empty !== 1'b1 || n_ae !== 1'b1) begin n_fail++; $display("FAIL areset_async: usedw %0d empty %b ae %b want 0 1 1", n_usedw, n_empty, n_ae); end
    n_checks++; if (n_dout !== 16'h0 || n_ovf !== 1'b0 || n_full !== 1'b0) begin n_fail++; $display("FAIL areset_outs: dout %h ovf %b full %b want 0000 0 0", n_dout, n_ovf, n_full); end
    #1 reset_n = 1'b1;
    tick();
    n_wr = 1'b1; n_din = 16'h0401;
    tick();
    n_din = 16'h0402;
    tick();
    n_wr = 1'b0; n_rd = 1'b1;
    tick();
    n_rd = 1'b0;
    n_checks++; if (n_dout !== 16'h0401 || n_usedw !== 5'd1) begin n_fail++; $display("FAIL areset_after: dout %h usedw %0d want 0401 1", n_dout, n_usedw); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_showahead();
    test_full_simul();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
